clk_div_multi: RTL and testbench

- Parametrised, multi-channel successor to the single fixed-rate clock divider.
- Generates N_CH independent divided clocks, each with its own runtime-programmable half-period and enable.
- Each channel also produces a one-cycle rising-edge tick, so logic that stays on clk can use the tick as a clock enable.
- A global sync input phase-aligns all channels. Sits between the board clock and the slow-rate logic (blinkers, display scan, debouncers).

---
 rtl/clk_div_multi.sv | 65 ++++++
 tb/tb_clk_div_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi.sv
// ============================================================================
// Module   : clk_div_multi
// Brief    : N_CH independent programmable clock dividers with rising-edge
//            ticks, shadowed divisors and a global phase-align input.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clk_div_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 20,
  parameter int DEFAULT_DIV = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic                  sync,
  input  logic [N_CH*CNT_W-1:0] div_val,
  output logic [N_CH-1:0]       sclk,
  output logic [N_CH-1:0]       tick
);

  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_one         = CNT_W'(1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_act_div;
    logic             r_sclk;
    logic             r_tick;
    logic [CNT_W-1:0] w_div;

    assign w_div = div_val[i*CNT_W +: CNT_W];

    // The divisor is only sampled at a wrap (or while idle), so a new value
    // never shortens the half-period already in progress.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_cnt     <= '0;
        r_act_div <= c_default_div;
        r_sclk    <= 1'b0;
        r_tick    <= 1'b0;
      end else if (sync || !en[i]) begin
        r_cnt     <= '0;
        r_act_div <= w_div;
        r_sclk    <= 1'b0;
        r_tick    <= 1'b0;
      end else if (r_cnt == r_act_div) begin
        r_cnt     <= '0;
        r_act_div <= w_div;
        r_sclk    <= ~r_sclk;
        r_tick    <= ~r_sclk;
      end else begin
        r_cnt     <= r_cnt + c_one;
        r_tick    <= 1'b0;
      end
    end

    assign sclk[i] = r_sclk;
    assign tick[i] = r_tick;
  end

endmodule

`default_nettype wire

// File: tb/tb_clk_div_multi.sv
// ============================================================================
// Module   : tb_clk_div_multi
// Brief    : Directed self-checking bench for clk_div_multi.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clk_div_multi;

  localparam int N_CH        = 4;
  localparam int CNT_W       = 8;
  localparam int DEFAULT_DIV = 200;

  logic                  clk;
  logic                  rst_n;
  logic [N_CH-1:0]       en;
  logic                  sync;
  logic [N_CH*CNT_W-1:0] div_val;
  logic [N_CH-1:0]       sclk;
  logic [N_CH-1:0]       tick;
  logic [CNT_W-1:0]      dv [N_CH];

  int total = 0;
  int bad   = 0;

  clk_div_multi #(
    .N_CH        (N_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .div_val (div_val),
    .sclk    (sclk),
    .tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    div_val = '0;
    for (int i = 0; i < N_CH; i++) div_val[i*CNT_W +: CNT_W] = dv[i];
  end

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    step();
    total++;
    if (sclk !== 4'b0000 || tick !== 4'b0000) begin
      bad++;
      $display("FAIL sync_clear: sclk=%b tick=%b required 0000/0000", sclk, tick);
    end
    sync = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sync  = 1'b0;
    en    = 4'b1111;
    for (int i = 0; i < N_CH; i++) dv[i] = 8'd2;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (sclk !== 4'b0000 || tick !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc%0d: sclk=%b tick=%b required 0000/0000", k, sclk, tick);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      total++;
      if (sclk !== 4'b0000 || tick !== 4'b0000) begin
        bad++;
        $display("FAIL reset_default_div edge%0d: sclk=%b tick=%b required 0000/0000", k, sclk, tick);
      end
    end
  endtask

  task automatic test_basic();
    logic es, et;
    en    = 4'b0000;
    dv[0] = 8'd2;
    sync_pulse();
    en = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      step();
      es = ((k / 3) % 2) == 1;
      et = (k % 6) == 3;
      total++;
      if (sclk !== {3'b000, es} || tick !== {3'b000, et}) begin
        bad++;
        $display("FAIL basic_div2 edge%0d: sclk=%b tick=%b required %b/%b", k, sclk, tick, {3'b000, es}, {3'b000, et});
      end
    end
  endtask

  task automatic test_div0();
    logic e;
    en    = 4'b0000;
    dv[1] = 8'd0;
    sync_pulse();
    en = 4'b0010;
    for (int k = 1; k <= 8; k++) begin
      step();
      e = (k % 2) == 1;
      total++;
      if (sclk !== {2'b00, e, 1'b0} || tick !== {2'b00, e, 1'b0}) begin
        bad++;
        $display("FAIL div0 edge%0d: sclk=%b tick=%b required %b/%b", k, sclk, tick, {2'b00, e, 1'b0}, {2'b00, e, 1'b0});
      end
    end
  endtask

  task automatic test_div_change();
    logic es, et;
    en    = 4'b0000;
    dv[0] = 8'd4;
    sync_pulse();
    en = 4'b0001;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 2) dv[0] = 8'd1;
      es = (k >= 5) && ((((k - 5) / 2) % 2) == 0);
      et = (k == 5) || (k == 9) || (k == 13);
      total++;
      if (sclk[0] !== es || tick[0] !== et) begin
        bad++;
        $display("FAIL div_change edge%0d: sclk0=%b tick0=%b required %b/%b", k, sclk[0], tick[0], es, et);
      end
    end
  endtask

  task automatic test_disable();
    en    = 4'b0000;
    dv[2] = 8'd1;
    sync_pulse();
    en = 4'b0100;
    step();
    step();
    step();
    total++;
    if (sclk[2] !== 1'b1 || tick[2] !== 1'b0) begin
      bad++;
      $display("FAIL disable_pre: sclk2=%b tick2=%b required 1/0", sclk[2], tick[2]);
    end
    en    = 4'b0000;
    dv[2] = 8'd3;
    for (int k = 1; k <= 3; k++) begin
      step();
      total++;
      if (sclk !== 4'b0000 || tick !== 4'b0000) begin
        bad++;
        $display("FAIL disable_hold edge%0d: sclk=%b tick=%b required 0000/0000", k, sclk, tick);
      end
    end
    en = 4'b0100;
    for (int k = 1; k <= 4; k++) begin
      step();
      total++;
      if (sclk[2] !== (k == 4) || tick[2] !== (k == 4)) begin
        bad++;
        $display("FAIL reenable edge%0d: sclk2=%b tick2=%b required %b/%b", k, sclk[2], tick[2], (k == 4), (k == 4));
      end
    end
  endtask

  task automatic test_sync_align();
    logic e;
    en    = 4'b0000;
    dv[0] = 8'd3;
    dv[3] = 8'd3;
    sync_pulse();
    en = 4'b0001;
    step();
    step();
    en = 4'b1001;
    for (int k = 0; k < 5; k++) step();
    sync_pulse();
    for (int k = 1; k <= 16; k++) begin
      step();
      e = ((k / 4) % 2) == 1;
      total++;
      if (sclk[0] !== e || sclk[3] !== e) begin
        bad++;
        $display("FAIL sync_align edge%0d: sclk0=%b sclk3=%b required %b", k, sclk[0], sclk[3], e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic saw;
    en = 4'b0000;
    for (int i = 0; i < N_CH; i++) dv[i] = 8'd1;
    sync_pulse();
    en  = 4'b1111;
    saw = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (sclk == 4'b1111) saw = 1'b1;
    end
    total++;
    if (saw !== 1'b1) begin
      bad++;
      $display("FAIL premid_toggle: all_high_seen=%b required 1", saw);
    end
    rst_n = 1'b0;
    step();
    total++;
    if (sclk !== 4'b0000 || tick !== 4'b0000) begin
      bad++;
      $display("FAIL reset_mid: sclk=%b tick=%b required 0000/0000", sclk, tick);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 201; k++) begin
      step();
      if (k < 201) begin
        total++;
        if (sclk !== 4'b0000 || tick !== 4'b0000) begin
          bad++;
          $display("FAIL reset_resume edge%0d: sclk=%b tick=%b required 0000/0000", k, sclk, tick);
        end
      end else begin
        total++;
        if (sclk !== 4'b1111 || tick !== 4'b1111) begin
          bad++;
          $display("FAIL reset_resume_rise: sclk=%b tick=%b required 1111/1111", sclk, tick);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sync  = 1'b0;
    en    = '0;
    for (int i = 0; i < N_CH; i++) dv[i] = '0;
    test_reset();
    test_basic();
    test_div0();
    test_div_change();
    test_disable();
    test_sync_align();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
